// File: rtl/imm_extend_queue.sv
// imm_extend_queue: decode-stage immediate generator feeding a DEPTH-entry FIFO
//   clk, rst (async, active-high), flush (sync clear of queued entries)
//   in_valid/in_ready + instr/imm_src : upstream push side
//   out_valid/out_ready + imm_ext/imm_err : downstream pop side (head entry)
//   count : occupied entries
module imm_extend_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  instr,
   input  logic [2:0]                   imm_src,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [XLEN-1:0]              imm_ext,
   output logic                         imm_err,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int aw = $clog2(DEPTH);
   localparam int cw = $clog2(DEPTH+1);
   logic [63:0]     wide;
   logic            err_in;
   logic [XLEN-1:0] mem [DEPTH];
   logic [DEPTH-1:0] err_mem;
   logic [aw-1:0]   wptr, rptr;
   logic            push, pop;
   // every format is built at 64 bits and truncated, so XLEN=32 and 64 share one path
   always_comb begin
      wide = imm_src == 3'd0 ? {{52{instr[31]}}, instr[31:20]} :
             imm_src == 3'd1 ? {{52{instr[31]}}, instr[31:25], instr[11:7]} :
             imm_src == 3'd2 ? {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
             imm_src == 3'd3 ? {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
             imm_src == 3'd4 ? {{32{instr[31]}}, instr[31:12], 12'h000} :
             imm_src == 3'd5 ? {59'd0, instr[19:15]} :
             imm_src == 3'd6 ? {58'd0, instr[25:20]} : 64'd0;
      err_in = imm_src == 3'b111;
   end
   assign in_ready  = count != cw'(DEPTH);
   assign out_valid = count != '0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign imm_ext   = out_valid ? mem[rptr] : '0;
   assign imm_err   = out_valid && err_mem[rptr];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= push ? wptr + aw'(1) : wptr;
         rptr  <= pop ? rptr + aw'(1) : rptr;
         count <= count + cw'(push) - cw'(pop);
      end
   end
   // payload storage needs no reset: it is masked whenever the queue is empty
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wptr]     <= wide[XLEN-1:0];
         err_mem[wptr] <= err_in;
      end
   end
endmodule
